// File: rtl/resp_demux.sv
// Return-path demultiplexer: routes response words to port A (fetch) or port B (load),
// each through its own small FIFO so back-pressure on one port never stalls the other.
module resp_demux #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [LW-1:0]    a_level,
    output logic [LW-1:0]    b_level
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [PW-1:0]    r_wp_a, r_rp_a, r_wp_b, r_rp_b;
    logic [LW-1:0]    r_lvl_a, r_lvl_b;

    logic w_push_a, w_push_b, w_pop_a, w_pop_b;

    // Full test uses registered levels only, so consumer ready never reaches in_ready.
    assign in_ready = (in_sel ? r_lvl_b : r_lvl_a) != LW'(DEPTH);

    assign w_push_a = in_valid & in_ready & ~in_sel;
    assign w_push_b = in_valid & in_ready &  in_sel;
    assign w_pop_a  = a_valid & a_ready;
    assign w_pop_b  = b_valid & b_ready;

    assign a_valid = (r_lvl_a != '0);
    assign b_valid = (r_lvl_b != '0);
    assign a_data  = r_mem_a[r_rp_a];
    assign b_data  = r_mem_b[r_rp_b];
    assign a_level = r_lvl_a;
    assign b_level = r_lvl_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp_a  <= '0;
            r_rp_a  <= '0;
            r_lvl_a <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem_a[i] <= '0;
        end else begin
            if (w_push_a) begin
                r_mem_a[r_wp_a] <= in_data;
                r_wp_a          <= r_wp_a + PW'(1);
            end
            if (w_pop_a) r_rp_a <= r_rp_a + PW'(1);
            case ({w_push_a, w_pop_a})
                2'b10:   r_lvl_a <= r_lvl_a + LW'(1);
                2'b01:   r_lvl_a <= r_lvl_a - LW'(1);
                default: r_lvl_a <= r_lvl_a;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp_b  <= '0;
            r_rp_b  <= '0;
            r_lvl_b <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem_b[i] <= '0;
        end else begin
            if (w_push_b) begin
                r_mem_b[r_wp_b] <= in_data;
                r_wp_b          <= r_wp_b + PW'(1);
            end
            if (w_pop_b) r_rp_b <= r_rp_b + PW'(1);
            case ({w_push_b, w_pop_b})
                2'b10:   r_lvl_b <= r_lvl_b + LW'(1);
                2'b01:   r_lvl_b <= r_lvl_b - LW'(1);
                default: r_lvl_b <= r_lvl_b;
            endcase
        end
    end
endmodule

// File: doc/resp_demux.md
# resp_demux

Routes a single stream of 32-bit words to one of two consumers, selected per word, with an independent FIFO in front of each consumer. It is the return-path counterpart of the 32-bit 2:1 word multiplexer. The multiplexer merges fetch and load requests onto the shared memory port. This block sends the memory port's response words back to the instruction-fetch side (port A) or the load side (port B). Back-pressure from one consumer never stalls words bound for the other.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 2, entries per output FIFO; power of two, ≥2
- LW, $clog2(DEPTH)+1, level counter width (derived, not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  incoming word
- in_sel  in  1  destination: 0 = port A, 1 = port B
- in_valid  in  1  in_data/in_sel valid
- in_ready  out  1  word accepted on this edge if in_valid
- a_data  out  WIDTH  head word of FIFO A
- a_valid  out  1  FIFO A non-empty
- a_ready  in  1  consumer A takes head word
- b_data  out  WIDTH  head word of FIFO B
- b_valid  out  1  FIFO B non-empty
- b_ready  in  1  consumer B takes head word
- a_level  out  LW  current occupancy of FIFO A
- b_level  out  LW  current occupancy of FIFO B

## Operation
- Accept condition: push = in_valid & in_ready, sampled on a rising clk edge.
- in_ready = (in_sel ? b_level : a_level) != DEPTH.
  - The full test uses registered levels only, so there is no combinational path from a_ready/b_ready to in_ready.
  - in_ready depends combinationally on in_sel, so the producer holds in_sel and in_data stable while in_valid is high.
- A push writes in_data into the FIFO selected by in_sel, at that FIFO's write pointer.
- Pop condition: pop_a = a_valid & a_ready, and likewise pop_b.
  - A pop advances the read pointer.
  - a_ready while a_valid = 0 has no effect.
- Each FIFO has read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Level is tracked separately.
- Level update per FIFO:
  - push only: +1
  - pop only: −1
  - both push and pop: unchanged, with both pointers advancing
  - neither: unchanged
- Push into a FIFO that is full, including the case where a pop happens in the same cycle: impossible, because in_ready is low.
- a_data is the storage entry at the read pointer; a_valid = (a_level != 0). Port B is identical.
- Ordering:
  - Words to the same port leave in acceptance order.
  - There is no ordering relation between ports A and B.
- No data is dropped or duplicated under any pattern of valid/ready.
- Reset (rst_n low, asynchronous):
  - all pointers and levels go to 0 and all storage entries to 0
  - therefore a_valid = b_valid = 0, a_data = b_data = 0, a_level = b_level = 0
  - in_ready = 1 while in reset
- Reset asserted mid-stream discards every buffered word. The first edge after deassertion behaves as from empty.

## Timing
- Latency: a word accepted at edge N is on a_data/b_data with valid high from just after edge N. Minimum residency is one cycle.
- Throughput: one word per cycle into each FIFO, provided the consumer pops every cycle and the FIFO is never full at the push edge.
- Pointers and levels register all state. a_data/b_data are a mux of storage by a registered pointer, with no combinational input-to-output path.
- in_ready rises the cycle after a pop frees a full FIFO, not in the same cycle.
- Deasserting rst_n is synchronised by the parent. The block requires only that rst_n does not release within setup/hold of clk.

## Test plan
- Reset:
  - Hold rst_n = 0, toggle inputs -> a_valid = b_valid = 0, levels = 0, data = 0, in_ready = 1.
  - Release rst_n -> state unchanged until the first push.
- Single routing:
  - Push 0xDEADBEEF with sel = 0, a_ready = 0 -> next cycle a_valid = 1, a_data = 0xDEADBEEF, a_level = 1, b_valid = 0.
  - Same with sel = 1 -> appears on port B only.
- Full/back-pressure:
  - a_ready = 0; push 0x1, 0x2 to A -> a_level = 2, in_ready = 0 for sel = 0 and 1 for sel = 1.
  - Then push 0x3 to B -> accepted.
  - Raise a_ready -> A delivers 0x1 then 0x2; in_ready for sel = 0 returns one cycle after the first pop.
- Simultaneous push/pop:
  - A holds 1 word, a_ready = 1, push 0x55 to A -> a_level stays 1, head advances to 0x55 next cycle.
- Wrap-around: stream 0x00..0x0F alternating A/B with random a_ready/b_ready -> A receives the even values in order, B the odd values in order, no loss or duplication, pointers wrap at least 4 times.
- Mid-stream reset: with both FIFOs full, pulse rst_n low between edges -> outputs go to 0 immediately (asynchronously); after release, push 0x77 to B -> b_data = 0x77, b_level = 1.
